// File: rtl/n_bit_reg_file_pkg.sv
// -----------------------------------------------------------------------------
// n_bit_reg_file_pkg
// Shared definitions for the ALU operand register file:
//   - default ALU datapath width, register count and hard-wired zero index
//   - read-source encoding used by the read-port muxes
//   - small helpers for address-width and zero-register decisions
// No ports (package).
// -----------------------------------------------------------------------------
package n_bit_reg_file_pkg;

  // Defaults for the ALU operand store.
  localparam int ALU_WIDTH    = 8;
  localparam int ALU_REGS     = 8;
  localparam int REG_ZERO_IDX = 0;

  // Number of registered read ports (A and B).
  localparam int NUM_RD_PORTS = 2;

  // Where a read port takes its next value from.
  typedef enum logic [1:0] {
    RD_SRC_ZERO   = 2'd0,  // out-of-range address or hard-wired zero entry
    RD_SRC_MEM    = 2'd1,  // stored entry contents
    RD_SRC_BYPASS = 2'd2   // write data accepted at the same edge
  } rd_src_e;

  // Address width with a floor of 1 bit so a degenerate depth still yields
  // a legal vector.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // True when entry idx is the constant-zero register.
  function automatic bit is_hardwired_zero(input int idx, input int r0_zero);
    return (r0_zero != 0) && (idx == REG_ZERO_IDX);
  endfunction

endpackage : n_bit_reg_file_pkg

// File: rtl/n_bit_reg_file_reg.sv
// -----------------------------------------------------------------------------
// n_bit_reg
// One storage entry of the register file: a WIDTH-bit register with
// synchronous active-high reset and load enable.
// Ports:
//   clk  in  1      rising-edge clock
//   rst  in  1      synchronous active-high reset, clears q
//   en   in  1      load enable; q <= d when high
//   d    in  WIDTH  next value
//   q    out WIDTH  stored value
// -----------------------------------------------------------------------------
module n_bit_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Hold unless loading.
  always_comb begin
    value_d = value_q;
    if (en) begin
      value_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign q = value_q;

endmodule : n_bit_reg

// File: rtl/n_bit_reg_file.sv
// -----------------------------------------------------------------------------
// n_bit_reg_file
// DEPTH x WIDTH ALU operand register file built from one n_bit_reg per entry.
// One write port, two registered read ports (A/B) with write-first bypass,
// global enable, synchronous clear-all and optional hard-wired zero entry.
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset (entries and outputs)
//   en       in   1      global enable; low freezes entries and outputs
//   clr      in   1      clear every entry and both outputs (needs en)
//   we       in   1      write enable
//   waddr    in   AW     write address (>= DEPTH is dropped)
//   wdata    in   WIDTH  write data
//   ra_addr  in   AW     port A read address
//   rb_addr  in   AW     port B read address
//   ra_data  out  WIDTH  port A data, one cycle after the address
//   rb_data  out  WIDTH  port B data, one cycle after the address
// -----------------------------------------------------------------------------
module n_bit_reg_file
  import n_bit_reg_file_pkg::*;
#(
  parameter  int WIDTH   = ALU_WIDTH,
  parameter  int DEPTH   = ALU_REGS,
  parameter  int R0_ZERO = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data
);

  genvar gi;

  // ---------------------------------------------------------------------------
  // Storage entries and write decode
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [DEPTH-1:0] wr_hit;    // write accepted into entry e at this edge
  logic [WIDTH-1:0] entry_d;   // shared next value for every entry

  // A clear loads zero into every entry; otherwise only the addressed entry
  // loads, and it loads wdata.
  assign entry_d = clr ? '0 : wdata;

  for (gi = 0; gi < DEPTH; gi++) begin : g_entry
    if ((R0_ZERO != 0) && (gi == REG_ZERO_IDX)) begin : g_zero
      // No storage: the zero register can never be written.
      assign wr_hit[gi]  = 1'b0;
      assign entry_q[gi] = '0;
    end else begin : g_reg
      logic entry_en;

      // Addresses >= DEPTH match no entry, so those writes fall away here.
      assign wr_hit[gi] = en & we & ~clr & (waddr == AW'(gi));
      assign entry_en   = en & (clr | wr_hit[gi]);

      n_bit_reg #(
        .WIDTH (WIDTH)
      ) u_reg (
        .clk (clk),
        .rst (rst),
        .en  (entry_en),
        .d   (entry_d),
        .q   (entry_q[gi])
      );
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: address mux with write-first bypass, then output register
  // ---------------------------------------------------------------------------
  logic [AW-1:0] rd_addr [NUM_RD_PORTS];

  assign rd_addr[0] = ra_addr;
  assign rd_addr[1] = rb_addr;

  for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
    rd_src_e          src_d;
    logic [WIDTH-1:0] mem_sel;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Scan the implemented entries; an address past DEPTH-1 matches nothing
    // and keeps the zero default.
    always_comb begin
      src_d   = RD_SRC_ZERO;
      mem_sel = '0;
      for (int e = 0; e < DEPTH; e++) begin
        if (rd_addr[gi] == AW'(e)) begin
          mem_sel = entry_q[e];
          if (is_hardwired_zero(e, R0_ZERO)) begin
            src_d = RD_SRC_ZERO;
          end else if (wr_hit[e]) begin
            src_d = RD_SRC_BYPASS;
          end else begin
            src_d = RD_SRC_MEM;
          end
        end
      end
    end

    always_comb begin
      case (src_d)
        RD_SRC_BYPASS: data_d = wdata;
        RD_SRC_MEM:    data_d = mem_sel;
        default:       data_d = '0;
      endcase
    end

    // Outputs follow the same priority as the entries: rst, hold, clear.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
      end else if (en) begin
        if (clr) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end
    end
  end

  assign ra_data = g_rd[0].data_q;
  assign rb_data = g_rd[1].data_q;

endmodule : n_bit_reg_file
